// File: rtl/weight_pingpong_loader_pkg.sv
// Shared definitions for the weight ping-pong loader; the state encoding and
// default widths are reused by Tile control and the Weight SRAM.
package weight_pingpong_loader_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_BANK = 2'd2,
        ST_DONE      = 2'd3
    } loader_state_e;

    // Clamp a requested macro length to the bank depth.
    function automatic logic [31:0] sat_rmc(input logic [31:0] rmc, input logic [31:0] depth);
        logic [31:0] res;
        if (rmc > depth) begin
            res = depth;
        end else begin
            res = rmc;
        end
        return res;
    endfunction

endpackage

// File: rtl/weight_pingpong_loader_if.sv
// Upstream weight stream plus Weight SRAM write port of the loader.
interface weight_pingpong_loader_if
    import weight_pingpong_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_bank, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_bank, wr_addr, wr_data
    );
endinterface

// File: rtl/weight_pingpong_loader_bank_flags.sv
// Two ping-pong bank full flags (set beats clear) with availability lookup
// for a selected target bank.
module pingpong_bank_flags (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       set_en,
    input  logic       set_bank,
    input  logic [1:0] clr,
    input  logic       sel,
    output logic [1:0] full,
    output logic       sel_avail
);
    logic [1:0] full_r;
    logic [1:0] set_s;

    // Decode the one-hot set request for the bank being completed.
    always_comb begin
        set_s = 2'b00;
        if (set_en) begin
            set_s = set_bank ? 2'b10 : 2'b01;
        end else begin
            set_s = 2'b00;
        end
    end

    // Flag register: a set on the same edge as a clear keeps the bank full.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            full_r <= 2'b00;
        end else begin
            full_r <= set_s | (full_r & ~clr);
        end
    end

    assign full      = full_r;
    // A bank being consumed this cycle is usable from the next edge on.
    assign sel_avail = !full_r[sel] || clr[sel];

endmodule

// File: rtl/weight_pingpong_loader.sv
// Streams weight words into alternating Weight SRAM banks, one macro per bank,
// stalling while the next bank still holds an unconsumed macro.
module weight_pingpong_loader
    import weight_pingpong_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   start,
    input  logic [31:0]            rmc_of_each_macro,
    input  logic [CNT_W-1:0]       num_macros,
    weight_pingpong_loader_if.slave bus,
    input  logic [1:0]             bank_consumed,
    output logic [1:0]             bank_full,
    output logic                   busy,
    output logic                   done
);
    localparam int          WC_W  = ADDR_W + 1;
    localparam int          MC_W  = CNT_W + 1;
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_e     state_r;
    logic              fill_bank_r;
    logic              last_bank_r;
    logic [WC_W-1:0]   rmc_r;
    logic [WC_W-1:0]   word_cnt_r;
    logic [CNT_W-1:0]  nmac_r;
    logic [CNT_W-1:0]  macro_cnt_r;
    logic              wr_en_r;
    logic              wr_bank_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              busy_r;
    logic              done_r;

    logic              in_ready_s;
    logic              xfer_s;
    logic              last_word_s;
    logic              last_macro_s;
    logic              tgt_bank_s;
    logic              tgt_avail_s;
    logic [1:0]        full_s;

    assign in_ready_s   = (state_r == ST_FILL) && !full_s[fill_bank_r];
    assign xfer_s       = bus.in_valid && in_ready_s;
    assign last_word_s  = (word_cnt_r == (rmc_r - WC_W'(1'b1)));
    assign last_macro_s = (({1'b0, macro_cnt_r} + MC_W'(1'b1)) == {1'b0, nmac_r});

    // Bank whose availability decides the next transition in each state.
    always_comb begin
        tgt_bank_s = fill_bank_r;
        case (state_r)
            ST_IDLE: tgt_bank_s = ~last_bank_r;
            ST_FILL: tgt_bank_s = ~fill_bank_r;
            default: tgt_bank_s = fill_bank_r;
        endcase
    end

    pingpong_bank_flags u_flags (
        .clk       (clk),
        .RSTn      (RSTn),
        .set_en    (xfer_s && last_word_s),
        .set_bank  (fill_bank_r),
        .clr       (bank_consumed),
        .sel       (tgt_bank_s),
        .full      (full_s),
        .sel_avail (tgt_avail_s)
    );

    // Loader FSM with its counters and the registered SRAM write port.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= ST_IDLE;
            fill_bank_r <= 1'b0;
            last_bank_r <= 1'b1;
            rmc_r       <= {WC_W{1'b0}};
            word_cnt_r  <= {WC_W{1'b0}};
            nmac_r      <= {CNT_W{1'b0}};
            macro_cnt_r <= {CNT_W{1'b0}};
            wr_en_r     <= 1'b0;
            wr_bank_r   <= 1'b0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            wr_en_r <= xfer_s;
            done_r  <= 1'b0;
            if (xfer_s) begin
                wr_bank_r <= fill_bank_r;
                wr_addr_r <= word_cnt_r[ADDR_W-1:0];
                wr_data_r <= bus.in_data;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rmc_r       <= WC_W'(sat_rmc(rmc_of_each_macro, DEPTH));
                        nmac_r      <= num_macros;
                        word_cnt_r  <= {WC_W{1'b0}};
                        macro_cnt_r <= {CNT_W{1'b0}};
                        fill_bank_r <= ~last_bank_r;
                        busy_r      <= 1'b1;
                        if (rmc_of_each_macro == 32'd0 || num_macros == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (!tgt_avail_s) begin
                            state_r <= ST_WAIT_BANK;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (xfer_s && last_word_s) begin
                        word_cnt_r  <= {WC_W{1'b0}};
                        last_bank_r <= fill_bank_r;
                        fill_bank_r <= ~fill_bank_r;
                        macro_cnt_r <= macro_cnt_r + CNT_W'(1'b1);
                        if (last_macro_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (!tgt_avail_s) begin
                            state_r <= ST_WAIT_BANK;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else if (xfer_s) begin
                        word_cnt_r <= word_cnt_r + WC_W'(1'b1);
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                end
                ST_WAIT_BANK: begin
                    if (tgt_avail_s) begin
                        state_r <= ST_FILL;
                    end else begin
                        state_r <= ST_WAIT_BANK;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_bank  = wr_bank_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign bank_full    = full_s;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_weight_pingpong_loader.sv
// Directed job table plus reset sequence for weight_pingpong_loader.
module tb_weight_pingpong_loader;

    typedef struct {
        int         rmc;
        int         nm;
        bit         tog;
        int         busy_start;
        int         c1_k;
        logic [1:0] c1_b;
        int         c2_k;
        logic [1:0] c2_b;
        bit         keep;
        int         exp_done;
        int         exp_wr;
        logic [1:0] exp_full;
    } vec_t;

    logic        clk;
    logic        RSTn;
    logic        start;
    logic [31:0] rmc;
    logic [7:0]  nm;
    logic [1:0]  bank_consumed;
    logic [1:0]  bank_full;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int next_bank = 0;
    vec_t vecs[13];

    weight_pingpong_loader_if #(.DATA_W(32), .ADDR_W(12)) bus();

    weight_pingpong_loader #(.DATA_W(32), .ADDR_W(12), .CNT_W(8)) dut (
        .clk               (clk),
        .RSTn              (RSTn),
        .start             (start),
        .rmc_of_each_macro (rmc),
        .num_macros        (nm),
        .bus               (bus),
        .bank_consumed     (bank_consumed),
        .bank_full         (bank_full),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One job: start on cycle 0, then observe/drive on each falling edge k.
    task automatic run_job(input int idx, input vec_t v);
        int          rs;
        int          sb;
        int          w;
        int          hs_cnt;
        int          done_k;
        int          budget;
        logic [31:0] base;
        logic [63:0] exp_w;
        rs     = (v.rmc > 4096) ? 4096 : v.rmc;
        sb     = next_bank;
        base   = 32'h5A00_0000 + 32'(idx) * 32'h0001_0000;
        w      = 0;
        hs_cnt = 0;
        done_k = 0;
        budget = v.exp_done + 20;
        @(negedge clk);
        start = 1'b1;
        rmc = 32'(v.rmc);
        nm = 8'(v.nm);
        bus.in_valid = 1'b0;
        bank_consumed = 2'b00;
        for (int k = 1; k <= budget && done_k == 0; k++) begin
            @(negedge clk);
            start = (k == v.busy_start);
            if (k == v.busy_start) begin
                rmc = 32'd99;
                nm  = 8'd7;
            end
            bank_consumed = (k == v.c1_k) ? v.c1_b : ((k == v.c2_k) ? v.c2_b : 2'b00);
            if (bus.wr_en) begin
                if (rs == 0) begin
                    check("write_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_w = {19'd0, 1'(sb ^ ((w / rs) % 2)), 12'(w % rs), base + 32'(w)};
                    check("write", {19'd0, bus.wr_bank, bus.wr_addr, bus.wr_data}, exp_w);
                end
                w++;
            end
            check("busy_in_job", 64'(busy), 64'd1);
            if (done) done_k = k;
            bus.in_valid = v.tog ? (k % 2 == 1) : 1'b1;
            bus.in_data  = base + 32'(hs_cnt);
            if (bus.in_valid && bus.in_ready) hs_cnt++;
        end
        check("done_cycle", 64'(done_k), 64'(v.exp_done));
        check("write_count", 64'(w), 64'(v.exp_wr));
        check("bank_full_at_done", 64'(bank_full), 64'(v.exp_full));
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
        bank_consumed = 2'b00;
        check("done_single_pulse", 64'(done), 64'd0);
        check("idle_not_busy", 64'(busy), 64'd0);
        check("no_write_after_done", 64'(bus.wr_en), 64'd0);
        if (!v.keep) begin
            bank_consumed = 2'b11;
            @(negedge clk);
            bank_consumed = 2'b00;
            check("flags_cleared", 64'(bank_full), 64'd0);
        end
        if (rs > 0 && v.nm > 0) next_bank = 1 - (sb ^ ((v.nm - 1) % 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rmc  nm tog bs c1 c1b   c2 c2b   keep done  wr    full
        vecs[0]  = '{4,    1, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 5,    4,    2'b01};
        vecs[1]  = '{5,    1, 1'b1, 0, 0,  2'b00, 0, 2'b00, 1'b0, 10,   5,    2'b10};
        vecs[2]  = '{8,    3, 1'b0, 0, 20, 2'b01, 0, 2'b00, 1'b0, 29,   24,   2'b11};
        vecs[3]  = '{0,    3, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 1,    0,    2'b00};
        vecs[4]  = '{3,    0, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 1,    0,    2'b00};
        vecs[5]  = '{2,    2, 1'b1, 0, 0,  2'b00, 0, 2'b00, 1'b0, 8,    4,    2'b11};
        vecs[6]  = '{4,    1, 1'b0, 2, 0,  2'b00, 0, 2'b00, 1'b0, 5,    4,    2'b10};
        vecs[7]  = '{2,    2, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b1, 5,    4,    2'b11};
        vecs[8]  = '{2,    1, 1'b0, 0, 3,  2'b10, 6, 2'b01, 1'b0, 9,    2,    2'b01};
        vecs[9]  = '{4096, 1, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 4097, 4096, 2'b10};
        vecs[10] = '{5000, 2, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 8193, 8192, 2'b11};
        vecs[11] = '{2,    1, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b1, 3,    2,    2'b01};
        vecs[12] = '{3,    1, 1'b0, 0, 0,  2'b00, 0, 2'b00, 1'b0, 4,    3,    2'b01};

        RSTn = 1'b0;
        start = 1'b0;
        rmc = 32'd0;
        nm = 8'd0;
        bank_consumed = 2'b00;
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_full", 64'(bank_full), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_wr_bank", 64'(bus.wr_bank), 64'd0);
        RSTn = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd0);

        for (int i = 0; i < 12; i++) run_job(i, vecs[i]);

        // Mid-job reset after three of eight words, with a fourth in flight.
        @(negedge clk);
        start = 1'b1;
        rmc = 32'd8;
        nm = 8'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data = 32'hDEAD_0000 + 32'(k);
        end
        @(negedge clk);
        check("pre_reset_full", 64'(bank_full), 64'd1);
        check("pre_reset_busy", 64'(busy), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEAD_0004;
        #2 RSTn = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("mid_rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("mid_rst_wr_bank", 64'(bus.wr_bank), 64'd0);
        check("mid_rst_full", 64'(bank_full), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("rst_drops_inflight", 64'(bus.wr_en), 64'd0);
        RSTn = 1'b1;
        bus.in_valid = 1'b0;
        next_bank = 0;
        run_job(12, vecs[12]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
